// File: rtl/tdm_demux.sv
// -----------------------------------------------------------------------------
// tdm_demux
//   Receive end of a time-division multiplexed link. Each valid beat carries
//   one channel word. Beats are steered into a staging buffer by slot
//   position. When the last slot arrives, the whole frame is published on
//   out_data. A start-of-frame marker (in_sof) delimits frames.
//
// Ports
//   clk        rising-edge clock
//   rst_n      asynchronous reset, active low
//   in_valid   in_sof / in_data carry a beat this cycle
//   in_sof     beat is slot 0 of a new frame
//   in_data    channel word of the current beat (W bits)
//   out_valid  one-cycle pulse: out_data holds a newly completed frame
//   out_data   last complete frame, slot i at [i*W +: W]
//   out_err    one-cycle pulse: framing error (stray beat or early sof)
// -----------------------------------------------------------------------------
module tdm_demux #(
  parameter int N_CH = 4,
  parameter int W    = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  input  logic              in_sof,
  input  logic [W-1:0]      in_data,
  output logic              out_valid,
  output logic [N_CH*W-1:0] out_data,
  output logic              out_err
);

  localparam int            CW   = (N_CH > 1) ? $clog2(N_CH) : 1;
  localparam logic [CW-1:0] LAST = CW'(N_CH - 1);

  typedef enum logic {
    S_IDLE    = 1'b0,
    S_COLLECT = 1'b1
  } state_t;

  state_t              r_state;
  state_t              w_state_nxt;
  logic [CW-1:0]       r_cnt;
  logic [CW-1:0]       w_cnt_nxt;
  logic [CW-1:0]       w_idx;
  logic                w_we;
  logic                w_done;
  logic                w_err;
  logic [N_CH*W-1:0]   r_stage;
  logic [N_CH*W-1:0]   w_frame;
  logic [N_CH*W-1:0]   r_out_data;
  logic                r_out_valid;
  logic                r_out_err;

  // State register, slot counter, staging buffer and registered outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= S_IDLE;
      r_cnt       <= '0;
      r_stage     <= '0;
      r_out_data  <= '0;
      r_out_valid <= 1'b0;
      r_out_err   <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_cnt       <= w_cnt_nxt;
      r_out_valid <= w_done;
      r_out_err   <= w_err;
      if (w_we) begin
        r_stage <= w_frame;
      end
      // Publish the merged frame so the final beat appears without an extra
      // cycle of latency through the staging buffer.
      if (w_done) begin
        r_out_data <= w_frame;
      end
    end
  end

  // Next-state logic
  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_we        = 1'b0;
    w_idx       = '0;
    w_done      = 1'b0;
    w_err       = 1'b0;
    if (in_valid) begin
      case (r_state)
        S_IDLE: begin
          if (in_sof) begin
            w_we = 1'b1;
            if (N_CH == 1) begin
              // A single-slot frame is complete on its sof beat.
              w_done = 1'b1;
            end else begin
              w_cnt_nxt   = CW'(1);
              w_state_nxt = S_COLLECT;
            end
          end else begin
            // Beat outside any frame: dropped and flagged.
            w_err = 1'b1;
          end
        end
        S_COLLECT: begin
          w_we = 1'b1;
          if (in_sof) begin
            // Early sof abandons the partial frame and restarts at slot 0.
            w_err     = 1'b1;
            w_cnt_nxt = CW'(1);
          end else begin
            w_idx = r_cnt;
            if (r_cnt == LAST) begin
              w_done      = 1'b1;
              w_cnt_nxt   = '0;
              w_state_nxt = S_IDLE;
            end else begin
              w_cnt_nxt = r_cnt + 1'b1;
            end
          end
        end
        default: begin
          w_state_nxt = S_IDLE;
          w_cnt_nxt   = '0;
        end
      endcase
    end
  end

  // Datapath steering: staging buffer with the current beat merged in
  always_comb begin
    w_frame = r_stage;
    if (w_we) begin
      w_frame[int'(w_idx)*W +: W] = in_data;
    end
  end

  assign out_valid = r_out_valid;
  assign out_data  = r_out_data;
  assign out_err   = r_out_err;

endmodule

// File: tb/tb_tdm_demux.sv
module tb_tdm_demux;

  typedef struct {
    bit          is_err;
    logic [31:0] data;
  } ev_t;

  logic        clk;
  logic        rst_n;
  logic        in_valid;
  logic        in_sof;
  logic [7:0]  in_data;
  logic        out_valid;
  logic [31:0] out_data;
  logic        out_err;

  logic        in1_valid;
  logic        in1_sof;
  logic [7:0]  in1_data;
  logic        out1_valid;
  logic [7:0]  out1_data;
  logic        out1_err;

  int          errors = 0;
  int          checks = 0;
  int          cyc = 0;
  int          last_vld = 0;
  int          prev_vld = 0;
  ev_t         q[$];
  ev_t         q1[$];
  logic [31:0] exp_out = '0;
  logic [7:0]  exp_out1 = '0;

  tdm_demux #(.N_CH(4), .W(8)) u_dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_sof(in_sof),
    .in_data(in_data), .out_valid(out_valid), .out_data(out_data),
    .out_err(out_err)
  );

  tdm_demux #(.N_CH(1), .W(8)) u_dut1 (
    .clk(clk), .rst_n(rst_n), .in_valid(in1_valid), .in_sof(in1_sof),
    .in_data(in1_data), .out_valid(out1_valid), .out_data(out1_data),
    .out_err(out1_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h", nm, got, exp);
    end
  endtask

  // Monitor for the 4-channel instance
  always @(negedge clk) begin
    if (rst_n && (out_valid || out_err)) begin
      chk("vld_err_exclusive", {31'b0, out_valid & out_err}, 32'h0);
      if (out_valid) begin
        prev_vld = last_vld;
        last_vld = cyc;
      end
      if (q.size() == 0) begin
        chk("unexpected_event", {30'b0, out_valid, out_err}, 32'h0);
      end else begin
        ev_t e;
        e = q.pop_front();
        chk("event_is_err", {31'b0, out_err}, {31'b0, e.is_err});
        chk("event_data", out_data, e.data);
      end
    end
  end

  // Monitor for the single-channel instance
  always @(negedge clk) begin
    if (rst_n && (out1_valid || out1_err)) begin
      if (q1.size() == 0) begin
        chk("n1_unexpected_event", {30'b0, out1_valid, out1_err}, 32'h0);
      end else begin
        ev_t e;
        e = q1.pop_front();
        chk("n1_event_is_err", {31'b0, out1_err}, {31'b0, e.is_err});
        chk("n1_event_data", {24'b0, out1_data}, e.data);
      end
    end
  end

  task automatic push_frame(input logic [31:0] d);
    ev_t e;
    e.is_err = 1'b0;
    e.data   = d;
    exp_out  = d;
    q.push_back(e);
  endtask

  task automatic push_err();
    ev_t e;
    e.is_err = 1'b1;
    e.data   = exp_out;
    q.push_back(e);
  endtask

  task automatic beat(input logic s, input logic [7:0] d);
    @(posedge clk);
    #1;
    in_valid = 1'b1;
    in_sof   = s;
    in_data  = d;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
      in_valid  = 1'b0;
      in_sof    = 1'b0;
      in_data   = 8'h00;
      in1_valid = 1'b0;
      in1_sof   = 1'b0;
      in1_data  = 8'h00;
    end
  endtask

  task automatic beat1(input logic s, input logic [7:0] d);
    ev_t e;
    if (s) begin
      e.is_err = 1'b0;
      e.data   = {24'b0, d};
      exp_out1 = d;
    end else begin
      e.is_err = 1'b1;
      e.data   = {24'b0, exp_out1};
    end
    q1.push_back(e);
    @(posedge clk);
    #1;
    in1_valid = 1'b1;
    in1_sof   = s;
    in1_data  = d;
  endtask

  task automatic drain(input string nm);
    for (int i = 0; i < 20; i++) begin
      if (q.size() == 0 && q1.size() == 0) break;
      @(negedge clk);
    end
    idle(2);
    chk({"drain_", nm}, q.size() + q1.size(), 32'h0);
  endtask

  initial begin
    rst_n     = 1'b0;
    in_valid  = 1'b0;
    in_sof    = 1'b0;
    in_data   = 8'h00;
    in1_valid = 1'b0;
    in1_sof   = 1'b0;
    in1_data  = 8'h00;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_out_valid", {31'b0, out_valid}, 32'h0);
    chk("rst_out_err", {31'b0, out_err}, 32'h0);
    chk("rst_out_data", out_data, 32'h0);
    rst_n = 1'b1;
    idle(2);

    // 1: one frame on consecutive beats
    beat(1'b1, 8'h11); beat(1'b0, 8'h22); beat(1'b0, 8'h33);
    push_frame(32'h44332211);
    beat(1'b0, 8'h44);
    idle(1);
    drain("t1");

    // 2: same frame with gaps
    beat(1'b1, 8'h11); idle(2);
    beat(1'b0, 8'h22); idle(3);
    beat(1'b0, 8'h33); idle(1);
    push_frame(32'h44332211);
    beat(1'b0, 8'h44);
    idle(1);
    drain("t2");

    // 3: stray beats in IDLE
    push_err(); beat(1'b0, 8'h55);
    push_err(); beat(1'b0, 8'h66);
    idle(1);
    drain("t3");
    chk("t3_data_held", out_data, 32'h44332211);

    // 4: early sof abandons partial frame
    beat(1'b1, 8'hAA); beat(1'b0, 8'hBB);
    push_err(); beat(1'b1, 8'h01);
    beat(1'b0, 8'h02); beat(1'b0, 8'h03);
    push_frame(32'h04030201);
    beat(1'b0, 8'h04);
    idle(1);
    drain("t4");

    // 5: back-to-back frames
    beat(1'b1, 8'h11); beat(1'b0, 8'h22); beat(1'b0, 8'h33);
    push_frame(32'h44332211);
    beat(1'b0, 8'h44);
    beat(1'b1, 8'h55); beat(1'b0, 8'h66); beat(1'b0, 8'h77);
    push_frame(32'h88776655);
    beat(1'b0, 8'h88);
    idle(1);
    drain("t5");
    chk("t5_spacing", last_vld - prev_vld, 32'd4);

    // 6: reset mid-frame discards the partial frame
    beat(1'b1, 8'hE1); beat(1'b0, 8'hE2);
    idle(1);
    #2;
    rst_n = 1'b0;
    #1;
    chk("t6_rst_valid", {31'b0, out_valid}, 32'h0);
    chk("t6_rst_err", {31'b0, out_err}, 32'h0);
    chk("t6_rst_data", out_data, 32'h0);
    chk("t6_rst_data_n1", {24'b0, out1_data}, 32'h0);
    exp_out = '0;
    idle(2);
    rst_n = 1'b1;
    idle(1);
    beat(1'b0, 8'h0A);  // no sof after reset: stray beat
    q.push_front('{is_err: 1'b1, data: 32'h0});
    idle(1);
    drain("t6_stray");
    beat(1'b1, 8'h0A); beat(1'b0, 8'h0B); beat(1'b0, 8'h0C);
    push_frame(32'h0D0C0B0A);
    beat(1'b0, 8'h0D);
    idle(1);
    drain("t6");

    // 6b: single-channel instance, every sof beat is a frame
    beat1(1'b1, 8'h5A);
    beat1(1'b1, 8'hA5);
    beat1(1'b0, 8'h77);
    beat1(1'b1, 8'h3C);
    idle(1);
    drain("t6_n1");
    chk("t6_n1_final", {24'b0, out1_data}, 32'h3C);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
